// File: rtl/apb_bridge_mp_pkg.sv
// Shared types and helpers for the parametrised AHB-to-APB bridge.
package apb_bridge_pkg;

  // Bridge transfer state: idle, APB setup phase, APB access phase, response cycle.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic RESP_OKAY  = 1'b0;
  localparam logic RESP_ERROR = 1'b1;

  // Width of the slave-index field; a single slave still needs one bit.
  function automatic int sel_width(input int nslv);
    return (nslv <= 1) ? 1 : $clog2(nslv);
  endfunction

endpackage

// File: rtl/apb_bridge_mp_if.sv
// Bus bundle for the bridge: simple AHB-side master port and the APB slave fan-out.
interface apb_bridge_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int NSLV   = 4
);
  logic                     Hen;
  logic                     Hwrite;
  logic [ADDR_W-1:0]        Haddr;
  logic [DATA_W-1:0]        Hwdata;
  logic                     Hready;
  logic [DATA_W-1:0]        Hrdata;
  logic                     Hresp;

  logic [ADDR_W-1:0]        Paddr;
  logic [NSLV-1:0]          Psel;
  logic                     Pen;
  logic                     Pwrite;
  logic [DATA_W-1:0]        Pwdata;
  logic [NSLV*DATA_W-1:0]   Prdata;
  logic [NSLV-1:0]          Pready;
  logic [NSLV-1:0]          Pslverr;

  modport ahb_master (output Hen, Hwrite, Haddr, Hwdata, input Hready, Hrdata, Hresp);
  modport ahb_slave  (input Hen, Hwrite, Haddr, Hwdata, output Hready, Hrdata, Hresp);
  modport apb_master (output Paddr, Psel, Pen, Pwrite, Pwdata, input Prdata, Pready, Pslverr);
  modport apb_slave  (input Paddr, Psel, Pen, Pwrite, Pwdata, output Prdata, Pready, Pslverr);
endinterface

// File: rtl/apb_bridge_mp_tick.sv
// APB phase-rate enable: one tick every PCLK_DIV clocks, restartable so a new
// transfer always gets full-length phases.
module apb_tick_gen #(
  parameter int PCLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);
  localparam int CNT_W = (PCLK_DIV <= 1) ? 1 : $clog2(PCLK_DIV);

  logic [CNT_W-1:0] cnt_reg, cnt_next;

  assign tick = (cnt_reg == CNT_W'(PCLK_DIV - 1));

  // Wrap at the tick, restart from zero on clear.
  always_comb begin
    cnt_next = cnt_reg + CNT_W'(1);
    if (clr || tick) cnt_next = '0;
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_reg <= '0;
    else        cnt_reg <= cnt_next;
  end
endmodule

// File: rtl/apb_bridge_mp.sv
// Parametrised AHB-to-APB bridge: address decode to NSLV slaves, APB wait
// states, slave error, access timeout and integrated APB phase-rate enable.
module apb_bridge_mp
  import apb_bridge_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int NSLV     = 4,
  parameter int SEL_LSB  = 28,
  parameter int PCLK_DIV = 2,
  parameter int TMO      = 15
) (
  input logic                HCLK,
  input logic                Hrst_n,
  apb_bridge_mp_if.ahb_slave  ahb,
  apb_bridge_mp_if.apb_master apb
);
  localparam int SEL_W = sel_width(NSLV);
  localparam int TMO_W = $clog2(TMO + 1);
  localparam logic [SEL_W:0] NSLV_L = (SEL_W + 1)'(NSLV);

  state_t              state_reg, state_next;
  logic [SEL_W-1:0]    idx_reg, idx_next;
  logic [ADDR_W-1:0]   paddr_reg, paddr_next;
  logic                pwrite_reg, pwrite_next;
  logic [DATA_W-1:0]   pwdata_reg, pwdata_next;
  logic [DATA_W-1:0]   hrdata_reg, hrdata_next;
  logic                hresp_reg, hresp_next;
  logic [TMO_W-1:0]    tmo_reg, tmo_next;

  logic                tick, accept, req_valid;
  logic [SEL_W-1:0]    req_idx;
  logic [DATA_W-1:0]   sel_rdata;
  logic                sel_ready, sel_err;

  assign ahb.Hready = (state_reg == IDLE) || (state_reg == DONE);
  assign ahb.Hrdata = hrdata_reg;
  assign ahb.Hresp  = hresp_reg;
  assign apb.Paddr  = paddr_reg;
  assign apb.Pwrite = pwrite_reg;
  assign apb.Pwdata = pwdata_reg;
  assign apb.Pen    = (state_reg == ACCESS);

  assign accept    = ahb.Hen && ahb.Hready;
  assign req_idx   = ahb.Haddr[SEL_LSB +: SEL_W];
  assign req_valid = ({1'b0, req_idx} < NSLV_L);

  apb_tick_gen #(.PCLK_DIV(PCLK_DIV)) u_tick (
    .clk   (HCLK),
    .rst_n (Hrst_n),
    .clr   (accept),
    .tick  (tick)
  );

  // idx_reg only holds an in-range index while SETUP/ACCESS, so an
  // out-of-range request can never raise a select.
  for (genvar gi = 0; gi < NSLV; gi++) begin : g_psel
    assign apb.Psel[gi] = ((state_reg == SETUP) || (state_reg == ACCESS)) &&
                          (idx_reg == SEL_W'(gi));
  end

  // Pick ready/error/read data of the selected slave; others are ignored.
  always_comb begin
    sel_rdata = '0;
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    for (int i = 0; i < NSLV; i++) begin
      if (idx_reg == SEL_W'(i)) begin
        sel_rdata = apb.Prdata[i*DATA_W +: DATA_W];
        sel_ready = apb.Pready[i];
        sel_err   = apb.Pslverr[i];
      end
    end
  end

  // Next-state and response logic; response regs are nonzero only in DONE.
  always_comb begin
    state_next  = state_reg;
    idx_next    = idx_reg;
    paddr_next  = paddr_reg;
    pwrite_next = pwrite_reg;
    pwdata_next = pwdata_reg;
    hrdata_next = '0;
    hresp_next  = RESP_OKAY;
    tmo_next    = tmo_reg;
    unique case (state_reg)
      IDLE, DONE: begin
        state_next = IDLE;
        if (ahb.Hen) begin
          idx_next    = req_idx;
          paddr_next  = ahb.Haddr;
          pwrite_next = ahb.Hwrite;
          pwdata_next = ahb.Hwdata;
          tmo_next    = '0;
          if (req_valid) begin
            state_next = SETUP;
          end else begin
            state_next = DONE;
            hresp_next = RESP_ERROR;
          end
        end
      end
      SETUP: begin
        if (tick) state_next = ACCESS;
      end
      ACCESS: begin
        if (tick) begin
          if (sel_ready) begin
            state_next  = DONE;
            hresp_next  = sel_err;
            hrdata_next = pwrite_reg ? '0 : sel_rdata;
          end else if (tmo_reg == TMO_W'(TMO - 1)) begin
            state_next = DONE;
            hresp_next = RESP_ERROR;
          end else begin
            tmo_next = tmo_reg + TMO_W'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, latched request and response registers.
  always_ff @(posedge HCLK or negedge Hrst_n) begin
    if (!Hrst_n) begin
      state_reg  <= IDLE;
      idx_reg    <= '0;
      paddr_reg  <= '0;
      pwrite_reg <= 1'b0;
      pwdata_reg <= '0;
      hrdata_reg <= '0;
      hresp_reg  <= RESP_OKAY;
      tmo_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      idx_reg    <= idx_next;
      paddr_reg  <= paddr_next;
      pwrite_reg <= pwrite_next;
      pwdata_reg <= pwdata_next;
      hrdata_reg <= hrdata_next;
      hresp_reg  <= hresp_next;
      tmo_reg    <= tmo_next;
    end
  end
endmodule

// File: tb/tb_apb_bridge_mp.sv
// Bench for apb_bridge_mp: two configurations (4 slaves / div 1 / tmo 15 and
// 3 slaves / div 2 / tmo 3) driven by directed and random transfers, each
// checked cycle by cycle against timing and responses derived from the
// transfer rules.
module tb_apb_bridge_mp;
  localparam int DIV_A = 1, TMO_A = 15, NS_A = 4;
  localparam int DIV_B = 2, TMO_B = 3,  NS_B = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Per-unit stimulus (0 = unit A, 1 = unit B), widened to 4 slaves.
  logic        hen [2];
  logic        hwrite [2];
  logic [31:0] haddr [2];
  logic [31:0] hwdata [2];
  logic [3:0]  pready [2];
  logic [3:0]  pslverr [2];
  logic [31:0] prdata [2][4];

  // Per-unit observations.
  logic        hready_o [2];
  logic        hresp_o [2];
  logic [31:0] hrdata_o [2];
  logic [3:0]  psel_o [2];
  logic        pen_o [2];
  logic [31:0] paddr_o [2];
  logic        pwrite_o [2];
  logic [31:0] pwdata_o [2];

  int checks = 0;
  int errors = 0;

  apb_bridge_mp_if #(.DATA_W(32), .ADDR_W(32), .NSLV(NS_A)) ifa ();
  apb_bridge_mp_if #(.DATA_W(32), .ADDR_W(32), .NSLV(NS_B)) ifb ();

  apb_bridge_mp #(.DATA_W(32), .ADDR_W(32), .NSLV(NS_A), .SEL_LSB(28),
                  .PCLK_DIV(DIV_A), .TMO(TMO_A)) dut_a (
    .HCLK(clk), .Hrst_n(rst_n), .ahb(ifa), .apb(ifa));
  apb_bridge_mp #(.DATA_W(32), .ADDR_W(32), .NSLV(NS_B), .SEL_LSB(28),
                  .PCLK_DIV(DIV_B), .TMO(TMO_B)) dut_b (
    .HCLK(clk), .Hrst_n(rst_n), .ahb(ifb), .apb(ifb));

  assign ifa.Hen = hen[0];  assign ifa.Hwrite = hwrite[0];
  assign ifa.Haddr = haddr[0];  assign ifa.Hwdata = hwdata[0];
  assign ifa.Pready = pready[0];  assign ifa.Pslverr = pslverr[0];
  assign ifa.Prdata = {prdata[0][3], prdata[0][2], prdata[0][1], prdata[0][0]};
  assign ifb.Hen = hen[1];  assign ifb.Hwrite = hwrite[1];
  assign ifb.Haddr = haddr[1];  assign ifb.Hwdata = hwdata[1];
  assign ifb.Pready = pready[1][2:0];  assign ifb.Pslverr = pslverr[1][2:0];
  assign ifb.Prdata = {prdata[1][2], prdata[1][1], prdata[1][0]};

  assign hready_o[0] = ifa.Hready;  assign hready_o[1] = ifb.Hready;
  assign hresp_o[0]  = ifa.Hresp;   assign hresp_o[1]  = ifb.Hresp;
  assign hrdata_o[0] = ifa.Hrdata;  assign hrdata_o[1] = ifb.Hrdata;
  assign psel_o[0]   = ifa.Psel;    assign psel_o[1]   = {1'b0, ifb.Psel};
  assign pen_o[0]    = ifa.Pen;     assign pen_o[1]    = ifb.Pen;
  assign paddr_o[0]  = ifa.Paddr;   assign paddr_o[1]  = ifb.Paddr;
  assign pwrite_o[0] = ifa.Pwrite;  assign pwrite_o[1] = ifb.Pwrite;
  assign pwdata_o[0] = ifa.Pwdata;  assign pwdata_o[1] = ifb.Pwdata;

  function automatic int div_of(input int u);
    return (u == 0) ? DIV_A : DIV_B;
  endfunction
  function automatic int tmo_of(input int u);
    return (u == 0) ? TMO_A : TMO_B;
  endfunction
  function automatic int ns_of(input int u);
    return (u == 0) ? NS_A : NS_B;
  endfunction

  // One transfer on unit u. Starts at a negedge with the unit able to accept;
  // returns at the negedge of its response cycle, leaving Hen low.
  task automatic run_txn(input int u, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input int waits, input logic err,
                         input logic [31:0] rdata, input string tag);
    int          idx, div, tmo, d;
    bit          valid, timeout;
    logic        exp_resp, exp_pen;
    logic [31:0] exp_rd;
    logic [3:0]  exp_sel;
    idx     = int'(addr[29:28]);
    div     = div_of(u);
    tmo     = tmo_of(u);
    valid   = idx < ns_of(u);
    timeout = valid && (waits >= tmo);
    // Response cycle: setup phase + (waits+1) access phases, or setup + tmo
    // access phases on timeout, or immediately for an unmapped index.
    d        = !valid ? 1 : (timeout ? 1 + div * (1 + tmo) : 1 + div * (2 + waits));
    exp_resp = !valid || timeout || err;
    exp_rd   = (valid && !timeout && !wr) ? rdata : 32'h0;
    exp_sel  = valid ? 4'(1 << idx) : 4'b0000;

    for (int i = 0; i < 4; i++) begin
      pready[u][i]  = 1'($urandom);
      pslverr[u][i] = 1'($urandom);
      prdata[u][i]  = $urandom;
    end
    if (valid) begin
      pready[u][idx]  = (waits == 0);
      pslverr[u][idx] = err;
      prdata[u][idx]  = rdata;
    end
    hen[u] = 1'b1; hwrite[u] = wr; haddr[u] = addr; hwdata[u] = wdata;
    @(posedge clk);
    for (int k = 1; k <= d; k++) begin
      @(negedge clk);
      if (k == 1) begin
        hen[u] = 1'b0; hwrite[u] = 1'($urandom);
        haddr[u] = $urandom; hwdata[u] = $urandom;
        if (valid) begin
          checks++;
          if ({paddr_o[u], pwrite_o[u], pwdata_o[u]} !== {addr, wr, wdata}) begin
            errors++;
            $display("FAIL %s apb_req u%0d: got addr=%h wr=%b wdata=%h expected addr=%h wr=%b wdata=%h",
                     tag, u, paddr_o[u], pwrite_o[u], pwdata_o[u], addr, wr, wdata);
          end
        end
      end
      if (k < d) begin
        exp_pen = (k > div);
        checks++;
        if ({hready_o[u], psel_o[u], pen_o[u]} !== {1'b0, exp_sel, exp_pen}) begin
          errors++;
          $display("FAIL %s busy u%0d k=%0d: got hready=%b psel=%b pen=%b expected hready=0 psel=%b pen=%b",
                   tag, u, k, hready_o[u], psel_o[u], pen_o[u], exp_sel, exp_pen);
        end
      end else begin
        checks++;
        if ({hready_o[u], hresp_o[u], hrdata_o[u], psel_o[u], pen_o[u]} !==
            {1'b1, exp_resp, exp_rd, 4'b0000, 1'b0}) begin
          errors++;
          $display("FAIL %s done u%0d k=%0d: got hready=%b hresp=%b hrdata=%h psel=%b pen=%b expected hready=1 hresp=%b hrdata=%h psel=0000 pen=0",
                   tag, u, k, hready_o[u], hresp_o[u], hrdata_o[u], psel_o[u], pen_o[u], exp_resp, exp_rd);
        end
      end
      // Slave model: ready comes up for the access phase after 'waits' low ticks.
      if (valid && !timeout && k >= 1 + div * (1 + waits)) pready[u][idx] = 1'b1;
    end
    $display("txn %s u%0d %s addr=%h wdata=%h waits=%0d err=%b -> hresp=%b hrdata=%h",
             tag, u, wr ? "WR" : "RD", addr, wdata, waits, err, hresp_o[u], hrdata_o[u]);
  endtask

  // One cycle later with no request: idle with cleared response.
  task automatic check_idle(input int u, input string tag);
    @(negedge clk);
    checks++;
    if ({hready_o[u], hresp_o[u], hrdata_o[u], psel_o[u], pen_o[u]} !== {1'b1, 1'b0, 32'h0, 4'b0000, 1'b0}) begin
      errors++;
      $display("FAIL %s idle u%0d: got hready=%b hresp=%b hrdata=%h psel=%b pen=%b expected 1 0 00000000 0000 0",
               tag, u, hready_o[u], hresp_o[u], hrdata_o[u], psel_o[u], pen_o[u]);
    end
  endtask

  task automatic test_reset();
    #12;
    for (int u = 0; u < 2; u++) begin
      checks++;
      if ({hready_o[u], hresp_o[u], hrdata_o[u], psel_o[u], pen_o[u], paddr_o[u], pwrite_o[u], pwdata_o[u]} !==
          {1'b1, 1'b0, 32'h0, 4'b0000, 1'b0, 32'h0, 1'b0, 32'h0}) begin
        errors++;
        $display("FAIL reset u%0d: got hready=%b hresp=%b hrdata=%h psel=%b pen=%b paddr=%h pwrite=%b pwdata=%h expected all zero except hready=1",
                 u, hready_o[u], hresp_o[u], hrdata_o[u], psel_o[u], pen_o[u], paddr_o[u], pwrite_o[u], pwdata_o[u]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    $display("txn reset released");
  endtask

  task automatic test_write_basic();
    run_txn(0, 1'b1, 32'h1000_0010, 32'hA5A5_0001, 0, 1'b0, 32'h0, "write_basic");
    check_idle(0, "write_basic");
  endtask

  task automatic test_read_wait();
    run_txn(0, 1'b0, 32'h3000_0000, 32'h0, 2, 1'b0, 32'hCAFE_F00D, "read_wait_a");
    check_idle(0, "read_wait_a");
    run_txn(1, 1'b0, 32'h2000_0004, 32'h0, 2, 1'b0, 32'hCAFE_F00D, "read_wait_b");
    check_idle(1, "read_wait_b");
  endtask

  task automatic test_slverr();
    run_txn(0, 1'b0, 32'h2000_0008, 32'h0, 0, 1'b1, 32'h1234_5678, "slverr");
    check_idle(0, "slverr");
  endtask

  task automatic test_bad_index();
    run_txn(1, 1'b0, 32'h3000_0000, 32'h0, 0, 1'b0, 32'h0, "bad_index");
    check_idle(1, "bad_index");
  endtask

  task automatic test_timeout();
    run_txn(0, 1'b0, 32'h1000_0000, 32'h0, TMO_A, 1'b0, 32'hDEAD_BEEF, "timeout_a");
    check_idle(0, "timeout_a");
    run_txn(1, 1'b1, 32'h0000_0020, 32'h5555_AAAA, TMO_B, 1'b0, 32'h0, "timeout_b");
    check_idle(1, "timeout_b");
  endtask

  task automatic test_back_to_back();
    run_txn(0, 1'b1, 32'h0000_0100, 32'h0BAD_F00D, 0, 1'b0, 32'h0, "b2b_1");
    run_txn(0, 1'b0, 32'h2000_0100, 32'h0, 1, 1'b0, 32'h7777_1111, "b2b_2");
    check_idle(0, "b2b_2");
    run_txn(1, 1'b0, 32'h3000_0000, 32'h0, 0, 1'b0, 32'h0, "b2b_3");
    run_txn(1, 1'b0, 32'h1000_0040, 32'h0, 1, 1'b0, 32'h9999_0000, "b2b_4");
    check_idle(1, "b2b_4");
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      int          u, waits;
      logic [31:0] addr;
      u     = int'($urandom_range(0, 1));
      addr  = $urandom;
      addr[29:28] = 2'($urandom_range(0, 3));
      waits = int'($urandom_range(0, tmo_of(u) + 1));
      run_txn(u, 1'($urandom), addr, $urandom, waits, ($urandom_range(0, 3) == 0),
              $urandom, "random");
      if ($urandom_range(0, 1) == 1) check_idle(u, "random");
    end
    check_idle(0, "random_end");
    check_idle(1, "random_end");
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 4; i++) pready[0][i] = 1'b0;
    hen[0] = 1'b1; hwrite[0] = 1'b0; haddr[0] = 32'h1000_0000; hwdata[0] = 32'h0;
    @(posedge clk);
    @(negedge clk); hen[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({psel_o[0], pen_o[0], hready_o[0]} !== {4'b0010, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL async_reset pre: got psel=%b pen=%b hready=%b expected 0010 1 0",
               psel_o[0], pen_o[0], hready_o[0]);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({psel_o[0], pen_o[0], hready_o[0], hresp_o[0]} !== {4'b0000, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL async_reset now: got psel=%b pen=%b hready=%b hresp=%b expected 0000 0 1 0",
               psel_o[0], pen_o[0], hready_o[0], hresp_o[0]);
    end
    $display("txn async reset asserted in ACCESS");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) pready[0][i] = 1'b1;
    check_idle(0, "after_reset");
    check_idle(0, "after_reset");
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      hen[u] = 1'b0; hwrite[u] = 1'b0; haddr[u] = 32'h0; hwdata[u] = 32'h0;
      pready[u] = 4'b1111; pslverr[u] = 4'b0000;
      for (int i = 0; i < 4; i++) prdata[u][i] = 32'h0;
    end
    test_reset();
    test_write_basic();
    test_read_wait();
    test_slverr();
    test_bad_index();
    test_timeout();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Backstop against a stalled run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
